mux_stream_rr: RTL and testbench

Parametrised N-channel streaming multiplexer. It selects one of N valid/ready input streams and forwards it through a single registered output stage. Two selection modes are supported: round-robin arbitration and externally fixed select. When enabled, packet locking holds a grant until the last beat of the packet. It is the clocked successor to the team's gate-level 2:1/8:1/16:1 select muxes and sits between multiple producers and one shared consumer.

---
 rtl/mux_stream_rr.sv | 163 ++++++++++++++++
 tb/tb_mux_stream_rr.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream mux with round-robin or fixed select and one registered output stage.
// Define MUX_STREAM_RR_LOCK_EN to hold a grant from the first beat of a packet until its in_last beat.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | arbitrating on every beat (round-robin or fixed select)
// ST_LOCKED  | mid-packet; grant pinned to r_lock_ch until its in_last beat
module mux_stream_rr #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_last
);

    localparam logic [SW:0] NCH = (SW+1)'(N);

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_last;
    logic [SW-1:0] r_ptr;

    logic          w_free;
    logic          w_rr_vld;
    logic [SW-1:0] w_rr_ch;
    logic [SW:0]   w_idx;
    logic          w_gnt_vld;
    logic [SW-1:0] w_gnt_ch;
    logic          w_gnt_valid_in;
    logic          w_gnt_last;
    logic [W-1:0]  w_gnt_data;
    logic          w_xfer;

`ifdef MUX_STREAM_RR_LOCK_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    state_t        r_state;
    logic [SW-1:0] r_lock_ch;
`endif

    assign w_free = ~r_out_valid | out_ready;

    // First valid channel at or after r_ptr, wrapping modulo N.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_ch  = '0;
        w_idx    = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, r_ptr} + (SW+1)'(i);
            if (w_idx >= NCH) w_idx = w_idx - NCH;
            if (!w_rr_vld && in_valid[w_idx]) begin
                w_rr_vld = 1'b1;
                w_rr_ch  = w_idx[SW-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        if (mode) begin
            w_gnt_vld = ({1'b0, sel} < NCH);
            w_gnt_ch  = sel;
        end else begin
            w_gnt_vld = w_rr_vld;
            w_gnt_ch  = w_rr_ch;
        end
`ifdef MUX_STREAM_RR_LOCK_EN
        if (r_state == ST_LOCKED) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = r_lock_ch;
        end
`endif
    end

    always_comb begin
        w_gnt_valid_in = 1'b0;
        w_gnt_last     = 1'b0;
        w_gnt_data     = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_ch == SW'(i)) begin
                w_gnt_valid_in = in_valid[i];
                w_gnt_last     = in_last[i];
                w_gnt_data     = in_data[i*W +: W];
            end
        end
    end

    assign w_xfer = w_gnt_vld & w_free & w_gnt_valid_in;

    // Ready ignores in_valid of the granted channel so producers may wait on it.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n & w_gnt_vld & w_free & (w_gnt_ch == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt_ch;
            r_out_last  <= w_gnt_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pointer only advances on round-robin transfers; fixed select leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer && !mode) begin
            r_ptr <= (w_gnt_ch == SW'(N-1)) ? '0 : w_gnt_ch + 1'b1;
        end
    end

`ifdef MUX_STREAM_RR_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_gnt_last) begin
                        r_state   <= ST_LOCKED;
                        r_lock_ch <= w_gnt_ch;
                    end
                end
                ST_LOCKED: begin
                    if (w_gnt_last) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: directed scenarios plus random traffic against a behavioural model.
// Lock scenarios add packet-level expectations when MUX_STREAM_RR_LOCK_EN is defined.
module tb_mux_stream_rr;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;
`ifdef MUX_STREAM_RR_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid, in_ready, in_last;
    logic [N*W-1:0] in_data;
    logic           mode, out_valid, out_ready, out_last;
    logic [SW-1:0]  sel, out_chan;
    logic [W-1:0]   out_data;

    logic [5:0]  v6, r6, l6;
    logic [47:0] d6;
    logic        mode6, ov6, ordy6, ol6;
    logic [2:0]  sel6, oc6;
    logic [7:0]  od6;

    mux_stream_rr #(.N(N), .W(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_last(out_last));

    mux_stream_rr #(.N(6), .W(8)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6),
        .in_data(d6), .in_last(l6), .mode(mode6), .sel(sel6),
        .out_valid(ov6), .out_ready(ordy6), .out_data(od6),
        .out_chan(oc6), .out_last(ol6));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_ptr, m_lock_ch, m_oc, m_g;
    bit         m_locked, m_ov, m_ol, m_gv, m_xfer;
    logic [W-1:0] m_od;
    logic [N-1:0] m_ready;

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_lock_ch = 0;
        m_ov = 0; m_od = '0; m_oc = 0; m_ol = 0;
    endtask

    // Grant = requester at the smallest forward distance from the pointer.
    task automatic model_comb();
        int best;
        bit free;
        m_gv = 0; m_g = 0; best = N;
        if (LOCK && m_locked) begin
            m_gv = 1; m_g = m_lock_ch;
        end else if (mode) begin
            if (int'(sel) < N) begin m_gv = 1; m_g = int'(sel); end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (in_valid[c] && ((c - m_ptr + N) % N) < best) begin
                    best = (c - m_ptr + N) % N; m_g = c; m_gv = 1;
                end
            end
        end
        free    = !m_ov || out_ready;
        m_ready = (rst_n && m_gv && free) ? (8'b1 << m_g) : 8'b0;
        m_xfer  = rst_n && m_gv && free && in_valid[m_g];
    endtask

    task automatic model_seq();
        if (m_xfer) begin
            m_ov = 1; m_od = in_data[m_g*W +: W]; m_oc = m_g; m_ol = in_last[m_g];
            if (!mode) m_ptr = (m_g + 1) % N;
            if (LOCK) begin
                if (!m_locked && !in_last[m_g]) begin m_locked = 1; m_lock_ch = m_g; end
                else if (m_locked && in_last[m_g]) m_locked = 0;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; in_valid = '0; in_last = '0; in_data = '0; mode = 0; sel = '0; out_ready = 1;
        v6 = '0; l6 = '0; d6 = '0; mode6 = 0; sel6 = '0; ordy6 = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; in_valid = '1; in_last = '1; mode = 0; out_ready = 1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'($urandom);
        model_reset();
        #1;
        n_checks++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=00", in_ready); end
        n_checks++; if ({out_valid, out_data, out_chan, out_last} !== 13'h0) begin
            n_fail++; $display("FAIL reset_outputs got v=%b d=%h c=%0d l=%b exp all zero", out_valid, out_data, out_chan, out_last); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held_valid got=%b exp=0", out_valid); end
        @(negedge clk); rst_n = 1; #1;
        n_checks++; if (in_ready !== 8'h01) begin n_fail++; $display("FAIL reset_first_grant got=%h exp=01", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_chan !== 3'd0) begin
            n_fail++; $display("FAIL reset_first_beat got v=%b c=%0d exp v=1 c=0", out_valid, out_chan); end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid = '1; in_last = '1; out_ready = 1; mode = 0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'hA0 + i);
        for (int k = 0; k <= N; k++) begin
            #1;
            n_checks++; if (in_ready !== (8'b1 << (k % N))) begin
                n_fail++; $display("FAIL rr_ready k=%0d got=%h exp=%h", k, in_ready, 8'b1 << (k % N)); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_chan !== 3'(k % N) || out_data !== 8'(8'hA0 + k % N)) begin
                n_fail++; $display("FAIL rr_beat k=%0d got v=%b c=%0d d=%h exp v=1 c=%0d d=%h",
                                   k, out_valid, out_chan, out_data, k % N, 8'(8'hA0 + k % N)); end
            @(negedge clk);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        in_valid = 8'hFF; in_last = 8'hFF; mode = 1; sel = 3'd5; out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'($urandom);
            #1;
            n_checks++; if (in_ready !== 8'h20) begin n_fail++; $display("FAIL fixed_ready k=%0d got=%h exp=20", k, in_ready); end
            tick();
            n_checks++; if (out_chan !== 3'd5 || out_data !== m_od || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL fixed_beat k=%0d got c=%0d d=%h v=%b exp c=5 d=%h v=1", k, out_chan, out_data, out_valid, m_od); end
            @(negedge clk);
        end
    endtask

    task automatic test_sel_range();
        logic [7:0] exp_d;
        do_reset();
        v6 = '1; l6 = '1; mode6 = 1; ordy6 = 1;
        for (int s = 6; s < 8; s++) begin
            sel6 = 3'(s);
            for (int k = 0; k < 2; k++) begin
                d6 = {$urandom, 16'($urandom)};
                #1;
                n_checks++; if (r6 !== 6'h00) begin n_fail++; $display("FAIL range_ready sel=%0d got=%h exp=00", s, r6); end
                @(posedge clk); #1;
                n_checks++; if (ov6 !== 1'b0) begin n_fail++; $display("FAIL range_valid sel=%0d got=%b exp=0", s, ov6); end
                @(negedge clk);
            end
        end
        sel6 = 3'd4; d6 = {$urandom, 16'($urandom)}; exp_d = d6[4*8 +: 8];
        #1;
        n_checks++; if (r6 !== 6'h10) begin n_fail++; $display("FAIL range_sel4_ready got=%h exp=10", r6); end
        @(posedge clk); #1;
        n_checks++; if (ov6 !== 1'b1 || oc6 !== 3'd4 || od6 !== exp_d) begin
            n_fail++; $display("FAIL range_sel4_beat got v=%b c=%0d d=%h exp v=1 c=4 d=%h", ov6, oc6, od6, exp_d); end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1; sel = 3'd1; in_valid = 8'h02; in_last = 8'hFF; out_ready = 1;
        in_data[1*W +: W] = 8'h3C;
        tick();
        n_checks++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_first got d=%h v=%b exp d=3c v=1", out_data, out_valid); end
        @(negedge clk);
        out_ready = 0; in_data[1*W +: W] = 8'h55;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_ready k=%0d got=%h exp=00", k, in_ready); end
            tick();
            n_checks++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold k=%0d got d=%h v=%b exp d=3c v=1", k, out_data, out_valid); end
            @(negedge clk);
        end
        out_ready = 1; #1;
        n_checks++; if (in_ready !== 8'h02) begin n_fail++; $display("FAIL bp_release_ready got=%h exp=02", in_ready); end
        tick();
        n_checks++; if (out_data !== 8'h55 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_next got d=%h v=%b exp d=55 v=1", out_data, out_valid); end
        @(negedge clk); in_valid = '0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h55) begin
            n_fail++; $display("FAIL bp_drain got v=%b d=%h exp v=0 d=55", out_valid, out_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid  = 8'($urandom);
            in_last   = 8'($urandom) | 8'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(3) != 0);
            mode      = ($urandom_range(7) == 0);
            sel       = 3'($urandom);
            #1;
            model_comb();
            n_checks++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL rand_ready k=%0d got=%h exp=%h", k, in_ready, m_ready); end
            tick();
            n_checks++; if ({out_valid, out_data, out_chan, out_last} !== {m_ov, m_od, 3'(m_oc), m_ol}) begin
                n_fail++; $display("FAIL rand_out k=%0d got v=%b d=%h c=%0d l=%b exp v=%b d=%h c=%0d l=%b",
                                   k, out_valid, out_data, out_chan, out_last, m_ov, m_od, m_oc, m_ol); end
            @(negedge clk);
        end
    endtask

    task automatic test_lock();
        int exp_ch [6] = '{2, 2, 2, 2, 3, 3};
        do_reset();
        mode = 0; sel = 3'd3; in_valid = 8'b0000_1100; out_ready = 1;
        for (int b = 0; b < 6; b++) begin
            in_data = {$urandom, $urandom};
            in_last = 8'h08 | ((b == 3) ? 8'h04 : 8'h00);
            if (b == 1) mode = 1;
            #1;
            model_comb();
            n_checks++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL lock_ready b=%0d got=%h exp=%h", b, in_ready, m_ready); end
            tick();
            n_checks++; if ({out_valid, out_data, out_chan, out_last} !== {m_ov, m_od, 3'(m_oc), m_ol}) begin
                n_fail++; $display("FAIL lock_out b=%0d got c=%0d d=%h exp c=%0d d=%h", b, out_chan, out_data, m_oc, m_od); end
`ifdef MUX_STREAM_RR_LOCK_EN
            n_checks++; if (out_chan !== 3'(exp_ch[b])) begin
                n_fail++; $display("FAIL lock_seq b=%0d got=%0d exp=%0d", b, out_chan, exp_ch[b]); end
`endif
            @(negedge clk);
        end
        if (exp_ch[0] != 2) $display("unexpected table");
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 0; in_valid = 8'h40; in_last = 8'h00; out_ready = 1;
        for (int b = 0; b < 2; b++) begin
            in_data = {$urandom, $urandom};
            tick();
            n_checks++; if (out_chan !== 3'd6 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL mid_beat b=%0d got c=%0d v=%b exp c=6 v=1", b, out_chan, out_valid); end
            @(negedge clk);
        end
        rst_n = 0; model_reset(); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset got v=%b rdy=%h exp v=0 rdy=00", out_valid, in_ready); end
        @(negedge clk); rst_n = 1; in_valid = 8'hFF; #1;
        n_checks++; if (in_ready !== 8'h01) begin n_fail++; $display("FAIL mid_regrant got=%h exp=01", in_ready); end
        tick();
        n_checks++; if (out_chan !== 3'd0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_first got c=%0d v=%b exp c=0 v=1", out_chan, out_valid); end
    endtask

    initial begin
        in_valid = '0; in_last = '0; in_data = '0; mode = 0; sel = '0; out_ready = 1;
        v6 = '0; l6 = '0; d6 = '0; mode6 = 0; sel6 = '0; ordy6 = 1;
        model_reset();
        test_reset();
        test_round_robin();
        test_fixed();
        test_sel_range();
        test_backpressure();
        test_lock();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
